// File: rtl/line_fill_buffer_pkg.sv
// line_fill_buffer_pkg: shared cache line geometry, fill-state encoding and word-slot helper.
package line_fill_buffer_pkg;
    localparam int WORDS  = 16;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;
    localparam int LINE_W = WORDS * WORD_W;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    typedef enum logic [1:0] {IDLE, REQ, FILL, HOLD} fill_state_t;
    // Word k of a line starts at bit k*w, the layout shared with the replacer and data array.
    function automatic int slot_lo(input int k, input int w = WORD_W);
        return k * w;
    endfunction
endpackage

// File: rtl/line_fill_buffer.sv
// line_fill_buffer: issues one block read per miss, gathers WORDS beats into a line and
// hands the registered line downstream over valid/ready.
module line_fill_buffer
    import line_fill_buffer_pkg::*;
#(
    parameter int WORDS  = line_fill_buffer_pkg::WORDS,
    parameter int WORD_W = line_fill_buffer_pkg::WORD_W,
    parameter int ADDR_W = line_fill_buffer_pkg::ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fill_start,
    input  logic [ADDR_W-1:0]         fill_addr,
    output logic                      busy,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_W-1:0]         mem_req_addr,
    input  logic                      mem_rvalid,
    output logic                      mem_rready,
    input  logic [WORD_W-1:0]         mem_rdata,
    output logic                      line_valid,
    input  logic                      line_ready,
    output logic [WORDS*WORD_W-1:0]   line_out
);
    localparam int LINE_W = WORDS * WORD_W;
    localparam int CNT_W  = $clog2(WORDS);

    fill_state_t       state, state_nxt;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            addr_q   <= '0;
            line_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && fill_start)
                addr_q <= fill_addr & ~ADDR_W'(LINE_W / 8 - 1);
            if (state == REQ && mem_req_ready)
                beat_cnt <= '0;
            // The last beat wraps beat_cnt back to zero on its own.
            if (state == FILL && mem_rvalid) begin
                line_q[slot_lo(int'(beat_cnt), WORD_W) +: WORD_W] <= mem_rdata;
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = fill_start ? REQ : IDLE;
            REQ:     state_nxt = mem_req_ready ? FILL : REQ;
            FILL:    state_nxt = (mem_rvalid && beat_cnt == CNT_W'(WORDS - 1)) ? HOLD : FILL;
            HOLD:    state_nxt = line_ready ? IDLE : HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy          = state != IDLE;
    assign mem_req_valid = state == REQ;
    assign mem_req_addr  = addr_q;
    assign mem_rready    = state == FILL;
    assign line_valid    = state == HOLD;
    assign line_out      = line_q;
endmodule

// File: tb/tb_line_fill_buffer.sv
// tb_line_fill_buffer: directed and randomized fills checked every cycle against a
// transaction-level model of the refill buffer.
module tb_line_fill_buffer;
    logic         clk = 0, rst = 1, fill_start = 0, mem_req_ready = 0, mem_rvalid = 0, line_ready = 0;
    logic [31:0]  fill_addr = 0, mem_rdata = 0;
    logic         busy, mem_req_valid, mem_rready, line_valid;
    logic [31:0]  mem_req_addr;
    logic [511:0] line_out;
    int           n_tests = 0, n_fail = 0;
    bit           chk_en = 0;

    // Model: a fill is active, its request accepted or not, and how many beats have landed.
    bit           m_active, m_acc;
    int           m_beats;
    logic [31:0]  m_addr;
    logic [511:0] m_line;

    always #5 clk = ~clk;

    line_fill_buffer dut (
        .clk(clk), .rst(rst), .fill_start(fill_start), .fill_addr(fill_addr), .busy(busy),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .line_valid(line_valid), .line_ready(line_ready), .line_out(line_out)
    );

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_acc = 0; m_beats = 0; m_addr = 0; m_line = '0;
        end else if (!m_active) begin
            if (fill_start) begin
                m_active = 1; m_acc = 0; m_beats = 0;
                m_addr = {fill_addr[31:6], 6'd0};
            end
        end else if (!m_acc) begin
            if (mem_req_ready) m_acc = 1;
        end else if (m_beats < 16) begin
            if (mem_rvalid) begin
                m_line[m_beats*32 +: 32] = mem_rdata;
                m_beats++;
            end
        end else if (line_ready) begin
            m_active = 0;
        end
    end

    always @(negedge clk) if (chk_en) begin
        check("busy", busy, m_active);
        check("mem_req_valid", mem_req_valid, m_active && !m_acc);
        check("mem_req_addr", mem_req_addr, m_addr);
        check("mem_rready", mem_rready, m_active && m_acc && m_beats < 16);
        check("line_valid", line_valid, m_active && m_acc && m_beats == 16);
        check("line_out", line_out, m_line);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fill(input logic [31:0] a);
        fill_addr = a; fill_start = 1;
        tick();
        fill_start = 0; fill_addr = $urandom;
    endtask

    // From REQ: wait req_wait cycles, then stream 16 beats (mode 0 back-to-back,
    // 1 alternating, 2 random), then sit in HOLD for hold_wait cycles.
    task automatic run_fill(input int req_wait, input int mode, input int hold_wait,
                            input logic [31:0] base, input bit pulse, input bit rel);
        int k = 0;
        int guard = 0;
        mem_req_ready = 0;
        repeat (req_wait) tick();
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        while (k < 16 && guard < 400) begin
            mem_rvalid = mode == 0 ? 1'b1 : mode == 1 ? 1'((guard % 2) == 0) : 1'($urandom_range(9) < 6);
            mem_rdata  = base + 32'(k);
            fill_start = pulse && guard == 3;
            fill_addr  = pulse ? 32'h0000_4000 : $urandom;
            tick();
            if (mem_rvalid) k++;
            guard++;
        end
        mem_rvalid = 0; fill_start = 0;
        check("beat_budget", 32'(k), 32'd16);
        line_ready = 0;
        repeat (hold_wait) tick();
        if (rel) begin
            line_ready = 1;
            tick();
            line_ready = 0;
        end
    endtask

    initial begin
        rst = 1;
        tick();
        chk_en = 1;
        tick();
        rst = 0;
        check("rst_busy", busy, 0);
        check("rst_addr", mem_req_addr, 0);
        check("rst_line", line_out, 0);

        // Basic fill with exact latency.
        start_fill(32'h0000_1234);
        check("basic_req_valid", mem_req_valid, 1);
        check("basic_req_addr", mem_req_addr, 32'h0000_1200);
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        for (int i = 0; i < 16; i++) begin
            mem_rvalid = 1;
            mem_rdata  = 32'hA0 + 32'(i);
            if (i == 15) check("basic_lv_early", line_valid, 0);
            tick();
        end
        mem_rvalid = 0;
        check("basic_lv_t18", line_valid, 1);
        check("basic_word0", line_out[31:0], 32'hA0);
        check("basic_word15", line_out[511:480], 32'hAF);
        line_ready = 1;
        tick();
        line_ready = 0;
        check("basic_idle", busy, 0);

        // Backpressure everywhere.
        start_fill(32'h0000_0a7c);
        run_fill(3, 1, 5, 32'h1100_0000, 0, 1);

        // Ignored start during FILL.
        start_fill(32'h0000_5008);
        run_fill(0, 0, 1, 32'h2200_0000, 1, 0);
        check("ign_addr", mem_req_addr, 32'h0000_5000);
        check("ign_lv", line_valid, 1);

        // Handshake collision: release this line while fill_start is already high.
        line_ready = 1; fill_start = 1; fill_addr = 32'h0000_9000;
        tick();
        line_ready = 0;
        check("coll_idle", busy, 0);
        check("coll_no_req", mem_req_valid, 0);
        tick();
        fill_start = 0;
        check("coll_req", mem_req_valid, 1);
        check("coll_addr", mem_req_addr, 32'h0000_9000);
        run_fill(1, 2, 1, 32'h3300_0000, 0, 1);

        // Reset after eight beats, then a clean fill.
        start_fill(32'h0000_2000);
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        for (int i = 0; i < 8; i++) begin
            mem_rvalid = 1;
            mem_rdata  = 32'hC0 + 32'(i);
            tick();
        end
        mem_rvalid = 0; rst = 1;
        tick();
        rst = 0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_lv", line_valid, 0);
        check("mid_rst_line", line_out, 0);
        check("mid_rst_rready", mem_rready, 0);
        mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        check("idle_rready", mem_rready, 0);
        mem_rvalid = 0;
        start_fill(32'h0000_3004);
        run_fill(0, 0, 0, 32'hD0, 0, 0);
        check("post_rst_word0", line_out[31:0], 32'hD0);
        check("post_rst_word15", line_out[511:480], 32'hDF);
        line_ready = 1;
        tick();
        line_ready = 0;

        // Randomized fills with idle noise on the non-start inputs.
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(3)) begin
                mem_rvalid = 1'($urandom_range(1)); mem_req_ready = 1'($urandom_range(1));
                line_ready = 1'($urandom_range(1)); mem_rdata = $urandom;
                tick();
            end
            mem_rvalid = 0; mem_req_ready = 0; line_ready = 0;
            start_fill($urandom);
            run_fill($urandom_range(3), $urandom_range(1, 2), $urandom_range(4), $urandom,
                     1'($urandom_range(1)), 1);
        end
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/line_fill_buffer.md
Name: line_fill_buffer

Overview:
- Refill stage directly upstream of the word replacer and the data array.
- On a miss, issues one block read to memory and collects 16 x 32-bit beats into a 512-bit line register.
- Presents the assembled line downstream through a valid/ready handshake.
- Word k of the line occupies bits [32k+31:32k], the same slot layout the replacer uses for word_offset.

Parameters:
- WORDS, 16, words per line (power of two, >=2).
- WORD_W, 32, bits per memory beat / word.
- ADDR_W, 32, byte-address width.
- Derived, not overridable:
  - LINE_W = WORDS*WORD_W.
  - OFF_W = log2(WORDS*WORD_W/8), the byte-offset bits within a line.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- fill_start  in  1  request a line fill; sampled only in IDLE.
- fill_addr  in  ADDR_W  any byte address inside the target line.
- busy  out  1  high in every state except IDLE.
- mem_req_valid  out  1  block read request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_W  line-aligned address (low OFF_W bits zero).
- mem_rvalid  in  1  read beat valid.
- mem_rready  out  1  buffer accepts a beat.
- mem_rdata  in  WORD_W  read beat data, in ascending word order.
- line_valid  out  1  assembled line available.
- line_ready  in  1  downstream consumes the line.
- line_out  out  LINE_W  assembled line, registered.

Behaviour:
- Reset: all of the following take effect on the next clk edge with rst=1.
  - State goes to IDLE; beat_cnt=0; address register=0; line register=0.
  - busy=0, mem_req_valid=0, mem_rready=0, line_valid=0, mem_req_addr=0, line_out=0.
- Reset mid-operation abandons the fill immediately. The memory side must be reset together with this block; beats arriving in IDLE are not accepted (mem_rready=0).
- State machine: IDLE, REQ, FILL, HOLD. All outputs are decoded from registered state and registers; no combinational path from any input to any output.
- IDLE:
  - When fill_start=1, latch fill_addr with low OFF_W bits forced to 0 and go to REQ.
  - When fill_start=0, stay in IDLE.
- REQ:
  - mem_req_valid=1 and mem_req_addr holds the latched address.
  - When mem_req_ready=1, go to FILL with beat_cnt=0.
  - Otherwise hold mem_req_valid and the address stable. Never withdraw a request.
- FILL:
  - mem_rready=1.
  - Each cycle with mem_rvalid=1 writes mem_rdata into word slot beat_cnt, then beat_cnt increments.
  - The beat accepted at beat_cnt=WORDS-1 goes to HOLD, and beat_cnt wraps to 0.
  - Cycles with mem_rvalid=0 are bubbles: no write, no count change.
- HOLD:
  - line_valid=1; line_out is stable and is not written.
  - When line_ready=1, go to IDLE.
  - fill_start in the same cycle as the line_ready handshake is ignored. The requester must hold it; it is accepted next cycle in IDLE.
- fill_start outside IDLE is ignored, and fill_addr changes are ignored after the latch.
- Latency:
  - fill_start at cycle t gives mem_req_valid at t+1.
  - With mem_req_ready=1 at t+1 and back-to-back beats from t+2, the last beat is at t+17 and line_valid rises at t+18.
- The line register is not cleared between fills. Every slot is overwritten before line_valid, so stale data is never visible.
- beat_cnt width is log2(WORDS). No overflow beyond WORDS beats is possible, because mem_rready drops on leaving FILL.

Decomposition:
- Shared cache package holds:
  - WORDS, WORD_W, LINE_W, OFF_W;
  - the fill-state enum (IDLE/REQ/FILL/HOLD);
  - the word-slot index function (32k base), shared with the replacer and data array.
- No sub-module. The beat counter and slot write decode are inline; an implementation is about 150 lines.

Test Plan:
- Basic fill: rst, then fill_start with fill_addr=0x0000_1234. Expect mem_req_addr=0x0000_1200. Send beats 0xA0..0xAF back-to-back. Expect line_valid at t+18 with line_out[31:0]=0xA0 and line_out[511:480]=0xAF; line_ready=1 returns to IDLE.
- Backpressure: mem_req_ready low for 3 cycles, mem_rvalid toggling 1/0, line_ready low for 5 cycles in HOLD.
  - mem_req_valid and address stay stable throughout REQ.
  - Exactly 16 writes, in order.
  - line_out is unchanged during HOLD.
- Ignored start: pulse fill_start with 0x0000_4000 during FILL. Expect no second request and the captured address unchanged.
- Handshake collision: line_ready=1 and fill_start=1 in the same HOLD cycle.
  - IDLE for one cycle.
  - The held fill_start is accepted next cycle; mem_req_valid rises 2 cycles after the handshake.
- Reset mid-fill: assert rst after beat 7.
  - Next cycle: busy=0, line_valid=0, line_out=0, mem_rready=0.
  - A fresh fill then completes normally with correct data in slot 0.
